// File: rtl/sdrc_req_split.sv
// rtl/sdrc_req_split.sv - splits one application request into page-bounded SDRAM sub-requests
module sdrc_req_split #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          cfg_colbits,
  input  logic                req_valid,
  input  logic [APP_AW:0]     req_addr,
  input  logic [APP_RW-1:0]   req_len,
  input  logic                req_wr_n,
  input  logic                req_dma_last,
  output logic                req_ack,
  output logic                sub_req,
  output logic [APP_AW:0]     sub_addr,
  output logic [APP_RW-1:0]   sub_len,
  output logic                sub_wr_n,
  output logic                sub_last,
  output logic                sub_dma_last,
  input  logic                sub_ack,
  output logic                busy
);

  localparam int AW = APP_AW + 1;
  localparam int CW = (APP_RW > 12) ? APP_RW : 12;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  logic [AW-1:0]       cur_addr;
  logic [APP_RW-1:0]   rem_len;
  logic                wr_n_r;
  logic                dma_r;
  logic [1:0]          cb_r;
  logic                req_ack_r;

  logic [3:0]          col_bits;
  logic [11:0]         page_size;
  logic [10:0]         col;
  logic [11:0]         room;
  logic [CW-1:0]       rem_ext;
  logic [CW-1:0]       room_ext;
  logic                fits;
  logic [APP_RW-1:0]   chunk;

  // Room left in the current page; a full page (col=0) gives 2^C, up to 2048.
  always_comb begin
    col_bits  = 4'd8 + {2'b00, cb_r};
    page_size = 12'd1 << col_bits;
    col       = cur_addr[10:0] & page_size[10:0] - 11'd1 & ~11'd0;
    col       = cur_addr[10:0] & (page_size[10:0] - 11'd1);
    room      = page_size - {1'b0, col};
    rem_ext   = CW'(rem_len);
    room_ext  = CW'(room);
    fits      = (rem_ext <= room_ext);
    // When the request does not fit, room < rem_len so it fits in APP_RW bits.
    chunk     = fits ? rem_len : APP_RW'(room);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem_len   <= '0;
      wr_n_r    <= 1'b1;
      dma_r     <= 1'b0;
      cb_r      <= 2'b00;
      req_ack_r <= 1'b0;
    end else begin
      req_ack_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr  <= req_addr;
            rem_len   <= (req_len == '0) ? APP_RW'(1) : req_len;
            wr_n_r    <= req_wr_n;
            dma_r     <= req_dma_last;
            cb_r      <= cfg_colbits;
            req_ack_r <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (sub_ack) begin
            if (fits) begin
              state <= IDLE;
            end else begin
              cur_addr <= cur_addr + AW'(chunk);
              rem_len  <= rem_len - chunk;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ack      = req_ack_r;
  assign sub_req      = (state == ISSUE);
  assign busy         = (state == ISSUE);
  assign sub_addr     = cur_addr;
  assign sub_len      = chunk;
  assign sub_wr_n     = wr_n_r;
  assign sub_last     = (state == ISSUE) && fits;
  assign sub_dma_last = sub_last && dma_r;

endmodule

// File: tb/tb_sdrc_req_split.sv
// tb/tb_sdrc_req_split.sv - directed-vector bench for sdrc_req_split
module tb_sdrc_req_split;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cfg_colbits;
  logic        req_valid;
  logic [30:0] req_addr;
  logic [8:0]  req_len;
  logic        req_wr_n;
  logic        req_dma_last;
  logic        req_ack;
  logic        sub_req;
  logic [30:0] sub_addr;
  logic [8:0]  sub_len;
  logic        sub_wr_n;
  logic        sub_last;
  logic        sub_dma_last;
  logic        sub_ack;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [30:0] exp_addr [4];
  logic [8:0]  exp_len  [4];
  logic        exp_last [4];

  always #5 clk = ~clk;

  sdrc_req_split #(.APP_AW(30), .APP_RW(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_colbits  (cfg_colbits),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wr_n     (req_wr_n),
    .req_dma_last (req_dma_last),
    .req_ack      (req_ack),
    .sub_req      (sub_req),
    .sub_addr     (sub_addr),
    .sub_len      (sub_len),
    .sub_wr_n     (sub_wr_n),
    .sub_last     (sub_last),
    .sub_dma_last (sub_dma_last),
    .sub_ack      (sub_ack),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_exp(input int i, input logic [30:0] a, input logic [8:0] l, input logic last);
    exp_addr[i] = a;
    exp_len[i]  = l;
    exp_last[i] = last;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sub_req"}, 32'(sub_req), 32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".req_ack"}, 32'(req_ack), 32'd0);
  endtask

  // Captures one request, then walks n_chunks expected sub-requests, stalling
  // sub_ack for 'stall' cycles in front of each chunk.
  task automatic do_req(input logic [1:0] cb, input logic [30:0] addr, input logic [8:0] len,
                        input logic wr, input logic dma, input int n_chunks, input int stall);
    bit first = 1'b1;
    cfg_colbits  = cb;
    req_addr     = addr;
    req_len      = len;
    req_wr_n     = wr;
    req_dma_last = dma;
    req_valid    = 1'b1;
    sub_ack      = 1'b0;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_addr     = ~addr;
    req_len      = ~len;
    req_wr_n     = ~wr;
    req_dma_last = ~dma;
    cfg_colbits  = ~cb;
    for (int i = 0; i < n_chunks; i++) begin
      for (int s = 0; s <= stall; s++) begin
        sub_ack = (s == stall);
        check($sformatf("c%0d.sub_req", i),  32'(sub_req),  32'd1);
        check($sformatf("c%0d.busy", i),     32'(busy),     32'd1);
        check($sformatf("c%0d.req_ack", i),  32'(req_ack),  32'(first));
        check($sformatf("c%0d.sub_addr", i), 32'(sub_addr), 32'(exp_addr[i]));
        check($sformatf("c%0d.sub_len", i),  32'(sub_len),  32'(exp_len[i]));
        check($sformatf("c%0d.sub_last", i), 32'(sub_last), 32'(exp_last[i]));
        check($sformatf("c%0d.dma_last", i), 32'(sub_dma_last), 32'(exp_last[i] & dma));
        check($sformatf("c%0d.sub_wr_n", i), 32'(sub_wr_n), 32'(wr));
        first = 1'b0;
        @(posedge clk); #1;
      end
    end
    sub_ack = 1'b0;
    check_idle("done");
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_colbits  = 2'b00;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_len      = '0;
    req_wr_n     = 1'b1;
    req_dma_last = 1'b0;
    sub_ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst.sub_addr", 32'(sub_addr), 32'd0);
    check("rst.sub_len",  32'(sub_len),  32'd0);
    check("rst.sub_wr_n", 32'(sub_wr_n), 32'd1);
    check("rst.sub_last", 32'(sub_last), 32'd0);
    check("rst.dma_last", 32'(sub_dma_last), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle("idle");

    set_exp(0, 31'h010, 9'd16, 1'b1);
    do_req(2'b00, 31'h010, 9'd16, 1'b0, 1'b0, 1, 0);

    set_exp(0, 31'h0F8, 9'd8, 1'b0);
    set_exp(1, 31'h100, 9'd8, 1'b1);
    do_req(2'b00, 31'h0F8, 9'd16, 1'b1, 1'b1, 2, 0);

    set_exp(0, 31'h080, 9'd128, 1'b0);
    set_exp(1, 31'h100, 9'd256, 1'b0);
    set_exp(2, 31'h200, 9'd127, 1'b1);
    do_req(2'b00, 31'h080, 9'd511, 1'b0, 1'b1, 3, 0);

    set_exp(0, 31'h080, 9'd511, 1'b1);
    do_req(2'b11, 31'h080, 9'd511, 1'b1, 1'b0, 1, 0);

    set_exp(0, 31'h0F8, 9'd8, 1'b0);
    set_exp(1, 31'h100, 9'd8, 1'b1);
    do_req(2'b00, 31'h0F8, 9'd16, 1'b0, 1'b1, 2, 5);

    set_exp(0, 31'h7FFFFFFC, 9'd4, 1'b0);
    set_exp(1, 31'h00000000, 9'd4, 1'b1);
    do_req(2'b00, 31'h7FFFFFFC, 9'd8, 1'b1, 1'b0, 2, 0);

    set_exp(0, 31'h005, 9'd1, 1'b1);
    do_req(2'b00, 31'h005, 9'd0, 1'b0, 1'b1, 1, 0);

    // Abandon the 0x080/511 request while its second chunk is pending.
    cfg_colbits  = 2'b00;
    req_addr     = 31'h080;
    req_len      = 9'd511;
    req_wr_n     = 1'b0;
    req_dma_last = 1'b1;
    req_valid    = 1'b1;
    sub_ack      = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ab.c0_addr", 32'(sub_addr), 32'h080);
    @(posedge clk); #1;
    sub_ack = 1'b0;
    check("ab.c1_addr", 32'(sub_addr), 32'h100);
    check("ab.c1_len",  32'(sub_len),  32'd256);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_idle("ab");
    check("ab.sub_wr_n", 32'(sub_wr_n), 32'd1);
    check("ab.sub_addr", 32'(sub_addr), 32'd0);
    check("ab.sub_len",  32'(sub_len),  32'd0);
    check("ab.sub_last", 32'(sub_last), 32'd0);
    sub_ack = 1'b1;
    @(posedge clk); #1;
    sub_ack = 1'b0;
    check_idle("ab2");

    set_exp(0, 31'h010, 9'd16, 1'b1);
    do_req(2'b00, 31'h010, 9'd16, 1'b0, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
